pp_accum_seq: RTL and testbench



---
 rtl/pp_accum_pkg.sv | 35 +++
 rtl/pp_align_shift.sv | 18 +
 rtl/pp_accum_seq.sv | 115 +++++++++++
 tb/tb_pp_accum_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pp_accum_pkg.sv
// Shared definitions for the serial partial-product accumulator.
//   - Geometry constants for partial-product width, limb radix and group layout.
//   - state_e: sequencer states (accumulate a group, present a group sum).
//   - pp_offset(): bit offset of a partial product from its group and slot.
package pp_accum_pkg;

   localparam int unsigned SIZE       = 43;
   localparam int unsigned RADIX      = 78;
   localparam int unsigned ACC_W      = 2 * RADIX;
   localparam int unsigned N_GRP      = 3;
   localparam int unsigned GRP_LEN    = 5;
   localparam int unsigned SLOT_SHIFT = 17;
   localparam int unsigned GRP_SHIFT  = 26;

   localparam int unsigned GRP_W  = 2;
   localparam int unsigned SLOT_W = 3;
   // Largest offset is 2*26 + 4*17 = 120, which fits in 7 bits.
   localparam int unsigned OFF_W  = 7;

   localparam logic [GRP_W-1:0]  LAST_GRP  = GRP_W'(N_GRP - 1);
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(GRP_LEN - 1);

   typedef enum logic {
      StAccum,
      StOut
   } state_e;

   function automatic logic [OFF_W-1:0] pp_offset(input logic [GRP_W-1:0]  grp,
                                                  input logic [SLOT_W-1:0] slot);
      int unsigned off;
      off = GRP_SHIFT * 32'(grp) + SLOT_SHIFT * 32'(slot);
      return OFF_W'(off);
   endfunction

endpackage

// File: rtl/pp_align_shift.sv
// Aligns one partial product to its bit offset inside the group accumulator.
// Ports:
//   pp_data  in   SIZE   partial product
//   offset   in   OFF_W  left-shift amount (0..120)
//   aligned  out  ACC_W  zero-extended, shifted value; bits beyond ACC_W are dropped
module pp_align_shift
   import pp_accum_pkg::*;
(
   input  logic [SIZE-1:0]  pp_data,
   input  logic [OFF_W-1:0] offset,
   output logic [ACC_W-1:0] aligned
);

   always_comb begin
      aligned = ACC_W'(pp_data) << offset;
   end

endmodule

// File: rtl/pp_accum_seq.sv
// Serial accumulator for the 15 partial products of one wide multiply.
// Each group of 5 beats is aligned and summed into a 2*RADIX-bit group sum
// with a single shared adder, then presented on a valid/ready result stream.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush                 synchronous abort back to reset values
//   pp_valid/pp_ready     partial-product input handshake
//   pp_data               partial product, index order 0..14
//   res_valid/res_ready   group-sum output handshake
//   res_data              group sum (mod 2^ACC_W)
//   res_grp, res_last     group index of res_data; high for the final group
//   busy                  an operation is partially consumed or a sum is pending
module pp_accum_seq
   import pp_accum_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             pp_valid,
   output logic             pp_ready,
   input  logic [SIZE-1:0]  pp_data,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [ACC_W-1:0] res_data,
   output logic [1:0]       res_grp,
   output logic             res_last,
   output logic             busy
);

   state_e              state_q, state_d;
   logic [GRP_W-1:0]    grp_q, grp_d;
   logic [SLOT_W-1:0]   slot_q, slot_d;
   logic [ACC_W-1:0]    acc_q, acc_d;

   logic [OFF_W-1:0]    offset;
   logic [ACC_W-1:0]    aligned;
   logic [ACC_W-1:0]    acc_base;
   logic                pp_fire;
   logic                res_fire;

   always_comb begin
      offset = pp_offset(grp_q, slot_q);
   end

   pp_align_shift u_align (
      .pp_data (pp_data),
      .offset  (offset),
      .aligned (aligned)
   );

   assign pp_fire  = pp_valid && (state_q == StAccum);
   assign res_fire = res_ready && (state_q == StOut);
   // Slot 0 starts a fresh group, so the previous sum is discarded rather than cleared.
   assign acc_base = (slot_q == '0) ? '0 : acc_q;

   always_comb begin
      state_d = state_q;
      grp_d   = grp_q;
      slot_d  = slot_q;
      acc_d   = acc_q;

      unique case (state_q)
         StAccum: begin
            if (pp_fire) begin
               acc_d = acc_base + aligned;
               if (slot_q == LAST_SLOT) begin
                  slot_d  = '0;
                  state_d = StOut;
               end else begin
                  slot_d = slot_q + SLOT_W'(1);
               end
            end
         end
         StOut: begin
            if (res_fire) begin
               state_d = StAccum;
               grp_d   = (grp_q == LAST_GRP) ? '0 : grp_q + GRP_W'(1);
            end
         end
         default: begin
            state_d = StAccum;
         end
      endcase

      if (flush) begin
         state_d = StAccum;
         grp_d   = '0;
         slot_d  = '0;
         acc_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StAccum;
         grp_q   <= '0;
         slot_q  <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         grp_q   <= grp_d;
         slot_q  <= slot_d;
         acc_q   <= acc_d;
      end
   end

   // All outputs decode registered state only; no input-to-output paths.
   assign pp_ready  = (state_q == StAccum);
   assign res_valid = (state_q == StOut);
   assign res_data  = acc_q;
   assign res_grp   = grp_q;
   assign res_last  = (grp_q == LAST_GRP);
   assign busy      = (state_q == StOut) || (grp_q != '0) || (slot_q != '0);

endmodule

// File: tb/tb_pp_accum_seq.sv
// Randomized bench for pp_accum_seq against a queue-based reference model.
module tb_pp_accum_seq;
   import pp_accum_pkg::*;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             pp_valid;
   logic             pp_ready;
   logic [SIZE-1:0]  pp_data;
   logic             res_valid;
   logic             res_ready;
   logic [ACC_W-1:0] res_data;
   logic [1:0]       res_grp;
   logic             res_last;
   logic             busy;

   always #5 clk = ~clk;

   pp_accum_seq dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .pp_valid  (pp_valid),
      .pp_ready  (pp_ready),
      .pp_data   (pp_data),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_grp   (res_grp),
      .res_last  (res_last),
      .busy      (busy)
   );

   typedef struct {
      logic [ACC_W-1:0] sum;
      logic [1:0]       grp;
      logic             last;
   } exp_t;

   exp_t            exp_q[$];   // group sums owed to the consumer
   logic [SIZE-1:0] beat_q[$];  // beats of the group being collected
   int              mgrp;       // index of the group being collected/presented
   int              n_checks = 0;
   int              n_fail   = 0;

   task automatic check_val(input string tag, input logic [ACC_W-1:0] got,
                            input logic [ACC_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Group sum straight from the offset rule: slot k of group g sits at 26*g + 17*k.
   function automatic logic [ACC_W-1:0] group_sum(input int g);
      logic [ACC_W-1:0] s;
      s = '0;
      for (int k = 0; k < 5; k++) begin
         s = s + (ACC_W'(beat_q[k]) << (26 * g + 17 * k));
      end
      return s;
   endfunction

   function automatic logic [SIZE-1:0] gen(input int mode, input int idx);
      logic [63:0] r;
      r = {$urandom, $urandom};
      case (mode)
         0:       return SIZE'(1);
         1:       return '1;
         3:       return (idx >= 10 && idx < 14) ? '0 : ((idx == 14) ? '1 : r[SIZE-1:0]);
         default: return r[SIZE-1:0];
      endcase
   endfunction

   task automatic check_outputs();
      logic in_out;
      in_out = (exp_q.size() != 0);
      check_val("pp_ready", ACC_W'(pp_ready), ACC_W'(!in_out));
      check_val("res_valid", ACC_W'(res_valid), ACC_W'(in_out));
      check_val("busy", ACC_W'(busy),
                ACC_W'(in_out || mgrp != 0 || beat_q.size() != 0));
      if (in_out) begin
         check_val("res_data", res_data, exp_q[0].sum);
         check_val("res_grp", ACC_W'(res_grp), ACC_W'(exp_q[0].grp));
         check_val("res_last", ACC_W'(res_last), ACC_W'(exp_q[0].last));
      end
   endtask

   // One clock: drive inputs, advance the model, then sample #1 after the edge.
   task automatic cyc(input logic v, input logic [SIZE-1:0] d, input logic rr,
                      input logic fl, input logic rs, output logic acc);
      logic in_out;
      in_out   = (exp_q.size() != 0);
      pp_valid = v;
      pp_data  = d;
      res_ready = rr;
      flush    = fl;
      rst      = rs;
      acc      = v && !in_out && !fl && !rs;
      if (fl || rs) begin
         exp_q.delete();
         beat_q.delete();
         mgrp = 0;
      end else if (rr && in_out) begin
         void'(exp_q.pop_front());
         mgrp = (mgrp + 1) % 3;
      end else if (acc) begin
         beat_q.push_back(d);
         if (beat_q.size() == 5) begin
            exp_t e;
            e.sum  = group_sum(mgrp);
            e.grp  = 2'(mgrp);
            e.last = (mgrp == 2);
            exp_q.push_back(e);
            beat_q.delete();
         end
      end
      @(posedge clk);
      #1;
      check_outputs();
      if (fl || rs) begin
         check_val("rst_res_data", res_data, '0);
         check_val("rst_res_grp", ACC_W'(res_grp), '0);
         check_val("rst_res_last", ACC_W'(res_last), '0);
      end
   endtask

   // Sends n beats (operation index start..) with random bubbles and drains results.
   task automatic feed(input int n, input int start, input int mode,
                       input int vprob, input int rprob);
      int   sent;
      int   cycles;
      logic acc;
      logic v;
      logic rr;
      sent   = 0;
      cycles = 0;
      while ((sent < n || exp_q.size() != 0) && cycles < 3000) begin
         v  = (sent < n) && (int'($urandom_range(99)) < vprob);
         rr = int'($urandom_range(99)) < rprob;
         cyc(v, gen(mode, (start + sent) % 15), rr, 1'b0, 1'b0, acc);
         if (acc) sent++;
         cycles++;
      end
      if (cycles >= 3000) check_val("feed_timeout", ACC_W'(sent), ACC_W'(n));
   endtask

   logic             a;
   logic [ACC_W-1:0] c0;
   logic [ACC_W-1:0] trunc_exp;

   initial begin
      mgrp      = 0;
      rst       = 1'b1;
      flush     = 1'b0;
      pp_valid  = 1'b0;
      pp_data   = '0;
      res_ready = 1'b0;
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, a);
      cyc(1'b1, '1, 1'b1, 1'b0, 1'b1, a);

      // bit-0 pattern; group 0 checked against a hand-built constant too
      for (int i = 0; i < 5; i++) cyc(1'b1, SIZE'(1), 1'b0, 1'b0, 1'b0, a);
      c0 = ACC_W'(1) + (ACC_W'(1) << 17) + (ACC_W'(1) << 34) + (ACC_W'(1) << 51)
           + (ACC_W'(1) << 68);
      check_val("bit0_grp0_const", res_data, c0);
      feed(10, 5, 0, 100, 100);

      // all-ones beats wrap mod 2^156
      feed(15, 0, 1, 100, 100);

      // truncation of group 2 slot 4
      feed(10, 0, 2, 100, 100);
      for (int i = 0; i < 4; i++) cyc(1'b1, '0, 1'b0, 1'b0, 1'b0, a);
      cyc(1'b1, '1, 1'b0, 1'b0, 1'b0, a);
      trunc_exp = ((ACC_W'(1) << 36) - ACC_W'(1)) << 120;
      check_val("trunc_const", res_data, trunc_exp);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, a);

      // backpressure: result held for 10 cycles while a beat is pending
      for (int i = 0; i < 5; i++) cyc(1'b1, gen(2, i), 1'b0, 1'b0, 1'b0, a);
      for (int i = 0; i < 10; i++) cyc(1'b1, gen(2, 5), 1'b0, 1'b0, 1'b0, a);
      cyc(1'b1, gen(2, 5), 1'b1, 1'b0, 1'b0, a);
      cyc(1'b1, gen(2, 5), 1'b1, 1'b0, 1'b0, a);
      feed(9, 6, 2, 100, 100);

      // four operations with random bubbles on both streams
      feed(60, 0, 2, 60, 60);

      // flush in the middle of group 1, then reset while group 0 is presented
      feed(7, 0, 2, 100, 100);
      cyc(1'b1, gen(2, 7), 1'b1, 1'b1, 1'b0, a);
      for (int i = 0; i < 5; i++) cyc(1'b1, gen(2, i), 1'b0, 1'b0, 1'b0, a);
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, a);
      cyc(1'b1, gen(2, 0), 1'b1, 1'b1, 1'b1, a);
      feed(15, 0, 2, 100, 100);

      // random operations with truncation-pattern group 2
      feed(30, 0, 3, 70, 70);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
